// File: rtl/sync_fifo_flagged_if.sv
// Handshake/status bundle for sync_fifo_flagged: producer/consumer side is master, FIFO is slave.
interface sync_fifo_flagged_if #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                      clear;
    logic                      w_en;
    logic [DATA_WIDTH-1:0]     data_in;
    logic                      r_en;
    logic [DATA_WIDTH-1:0]     data_out;
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic [$clog2(DEPTH):0]    count;
    logic                      overflow;
    logic                      underflow;

    modport master (
        output clear, w_en, data_in, r_en,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, w_en, data_in, r_en,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with full/empty, almost thresholds, count, overflow/underflow and flush.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through; default is registered read data.
module sync_fifo_flagged #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned AFULL_THRESH  = 6,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input logic                clk,
    input logic                rst_n,
    sync_fifo_flagged_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] w_ptr_q, w_ptr_d;
    logic [PW-1:0] r_ptr_q, r_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          full, empty, wr_acc, rd_acc;
    logic [AW-1:0] w_addr, r_addr;

    assign w_addr = w_ptr_q[AW-1:0];
    assign r_addr = r_ptr_q[AW-1:0];

    // Wrap bit distinguishes full from empty when the addresses coincide.
    assign empty = (w_ptr_q == r_ptr_q);
    assign full  = (w_ptr_q[AW] != r_ptr_q[AW]) && (w_addr == r_addr);

    assign wr_acc = bus.w_en && !full && !bus.clear;
    assign rd_acc = bus.r_en && !empty && !bus.clear;

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (bus.clear) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            overflow_d  = bus.w_en && full;
            underflow_d = bus.r_en && empty;
            if (wr_acc) w_ptr_d = w_ptr_q + PW'(1);
            if (rd_acc) r_ptr_d = r_ptr_q + PW'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[w_addr] <= bus.data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_out = empty ? '0 : mem[r_addr];
`else
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else if (bus.clear) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= mem[r_addr];
        end
    end

    assign bus.data_out = data_out_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AFULL_LVL);
    assign bus.almost_empty = (count_q <= AEMPTY_LVL);
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Directed self-checking bench for sync_fifo_flagged (DEPTH=8, DATA_WIDTH=8), both read modes.
module tb_sync_fifo_flagged;
`ifdef SYNC_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    sync_fifo_flagged_if #(.DEPTH(8), .DATA_WIDTH(8)) bus ();

    sync_fifo_flagged #(
        .DEPTH        (8),
        .DATA_WIDTH   (8),
        .AFULL_THRESH (6),
        .AEMPTY_THRESH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.w_en    = 1'b1;
        bus.data_in = d;
        step();
        bus.w_en    = 1'b0;
    endtask

    // FWFT shows the head before the pop; standard mode shows it one edge after.
    task automatic pop(input logic [7:0] exp);
        if (FWFT) check("pop_data_fwft", 32'(bus.data_out), 32'(exp));
        bus.r_en = 1'b1;
        step();
        bus.r_en = 1'b0;
        if (!FWFT) check("pop_data", 32'(bus.data_out), 32'(exp));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'd0);
        check({tag, "_empty"}, 32'(bus.empty), 32'd1);
        check({tag, "_aempty"}, 32'(bus.almost_empty), 32'd1);
        check({tag, "_full"}, 32'(bus.full), 32'd0);
        check({tag, "_afull"}, 32'(bus.almost_full), 32'd0);
        check({tag, "_dout"}, 32'(bus.data_out), 32'd0);
        check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        check({tag, "_unf"}, 32'(bus.underflow), 32'd0);
    endtask

    initial begin
        bus.clear   = 1'b0;
        bus.w_en    = 1'b0;
        bus.r_en    = 1'b0;
        bus.data_in = '0;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x11..0x18 and watch the flags track the count.
        for (int i = 0; i < 8; i++) begin
            push(8'(8'h11 + i));
            check("fill_count", 32'(bus.count), 32'(i + 1));
            check("fill_afull", 32'(bus.almost_full), 32'((i + 1) >= 6));
            check("fill_aempty", 32'(bus.almost_empty), 32'((i + 1) <= 2));
            check("fill_full", 32'(bus.full), 32'((i + 1) == 8));
            check("fill_empty", 32'(bus.empty), 32'd0);
        end

        push(8'hFF);
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd8);
        step();
        check("ovf_clear", 32'(bus.overflow), 32'd0);
        check("ovf_count2", 32'(bus.count), 32'd8);

        for (int i = 0; i < 8; i++) begin
            pop(8'(8'h11 + i));
            check("drain_count", 32'(bus.count), 32'(7 - i));
        end
        check("drain_empty", 32'(bus.empty), 32'd1);

        bus.r_en = 1'b1;
        step();
        bus.r_en = 1'b0;
        check("unf_pulse", 32'(bus.underflow), 32'd1);
        check("unf_dout", 32'(bus.data_out), FWFT ? 32'd0 : 32'h18);
        step();
        check("unf_clear", 32'(bus.underflow), 32'd0);
        check("unf_dout_hold", 32'(bus.data_out), FWFT ? 32'd0 : 32'h18);

        // Steady state at count 4 with both pointers wrapping.
        for (int i = 0; i < 4; i++) push(8'(8'h21 + i));
        for (int i = 0; i < 10; i++) begin
            if (FWFT) check("ss_data_fwft", 32'(bus.data_out), 32'(8'h21 + i));
            bus.w_en    = 1'b1;
            bus.r_en    = 1'b1;
            bus.data_in = 8'(8'h25 + i);
            step();
            if (!FWFT) check("ss_data", 32'(bus.data_out), 32'(8'h21 + i));
            check("ss_count", 32'(bus.count), 32'd4);
        end
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        for (int i = 0; i < 4; i++) pop(8'(8'h2B + i));
        check("ss_empty", 32'(bus.empty), 32'd1);

        // Full with both requests: read wins, write rejected.
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
        if (FWFT) check("fb_data_fwft", 32'(bus.data_out), 32'h31);
        bus.w_en    = 1'b1;
        bus.r_en    = 1'b1;
        bus.data_in = 8'hEE;
        step();
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        check("fb_ovf", 32'(bus.overflow), 32'd1);
        check("fb_count", 32'(bus.count), 32'd7);
        check("fb_full", 32'(bus.full), 32'd0);
        if (!FWFT) check("fb_data", 32'(bus.data_out), 32'h31);
        for (int i = 0; i < 7; i++) pop(8'(8'h32 + i));
        check("fb_empty", 32'(bus.empty), 32'd1);

        // Empty with both requests: write wins, read rejected.
        bus.w_en    = 1'b1;
        bus.r_en    = 1'b1;
        bus.data_in = 8'h77;
        step();
        bus.w_en = 1'b0;
        bus.r_en = 1'b0;
        check("eb_unf", 32'(bus.underflow), 32'd1);
        check("eb_count", 32'(bus.count), 32'd1);
        check("eb_dout", 32'(bus.data_out), FWFT ? 32'h77 : 32'h38);
        pop(8'h77);
        check("eb_count2", 32'(bus.count), 32'd0);

        // Flush at count 5 with a concurrent write.
        for (int i = 0; i < 5; i++) push(8'(8'h41 + i));
        bus.clear   = 1'b1;
        bus.w_en    = 1'b1;
        bus.data_in = 8'h99;
        step();
        bus.clear = 1'b0;
        bus.w_en  = 1'b0;
        check_reset_state("clear");
        step();
        check("clear_ovf2", 32'(bus.overflow), 32'd0);
        check("clear_count2", 32'(bus.count), 32'd0);

        // Single word into an empty FIFO, no read yet.
        push(8'hA5);
        check("a5_dout", 32'(bus.data_out), FWFT ? 32'hA5 : 32'd0);
        bus.r_en = 1'b1;
        step();
        bus.r_en = 1'b0;
        check("a5_empty", 32'(bus.empty), 32'd1);
        check("a5_dout_after", 32'(bus.data_out), FWFT ? 32'd0 : 32'hA5);

        // Asynchronous reset mid-burst, overflow pulse live.
        for (int i = 0; i < 8; i++) push(8'(8'h51 + i));
        bus.w_en    = 1'b1;
        bus.data_in = 8'h5F;
        step();
        check("pre_rst_ovf", 32'(bus.overflow), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        bus.w_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_reset_state("post_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
